// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared definitions for the sram port arbiter.
//   arb_state_e : 2-bit FSM state encoding (IDLE, ISSUE, WAIT, RESP)
//   PORT_I/D    : port ids used for grants and last-grant tracking
//   FETCH_BEN   : byte enables forced for instruction fetches
package sram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } arb_state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic [3:0] FETCH_BEN = 4'hF;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin picker, purely combinational.
//   req[1:0]   : request vector, indexed by port id (PORT_I, PORT_D)
//   last_grant : port id that won the previous arbitration
//   grant      : winning port id; only meaningful when |req
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    always_comb begin
        grant = PORT_I;
        if (req[PORT_I] && req[PORT_D]) begin
            // Tie: the port that did not win last time goes first.
            grant = ~last_grant;
        end else if (req[PORT_D]) begin
            grant = PORT_D;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-ported sram between the fetch port
// (read-only) and the data port (read/write, byte-enabled). One request is
// served at a time: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP.
//   gclk, reset                      : clock, synchronous active-high reset
//   i_req/i_addr                     : fetch request, held until i_ack
//   i_rdata/i_ack/i_error            : fetch response (valid with i_ack)
//   d_req/d_addr/d_wdata/d_b_en/d_w_en : data request, held until d_ack
//   d_rdata/d_ack/d_error            : data response (valid with d_ack)
//   mem_addr/mem_wdata/mem_b_en/mem_w_en : sram command
//   mem_rdata/mem_stall/mem_error    : sram response
//   busy                             : high whenever not IDLE
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              gclk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    output logic              i_error,

    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_b_en,
    input  logic              d_w_en,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_error,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_b_en,
    output logic              mem_w_en,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_stall,
    input  logic              mem_error,

    output logic              busy
);

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    arb_state_e state_q;
    logic       last_grant_q;
    logic       win_q;
    logic [3:0] cnt_q;
    logic       err_q;
    logic       grant;

    rr_arb2 u_rr_arb2 (
        .req        ({d_req, i_req}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign busy = (state_q != StIdle);

    always_ff @(posedge gclk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= PORT_D;
            win_q        <= PORT_I;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            i_rdata      <= '0;
            i_ack        <= 1'b0;
            i_error      <= 1'b0;
            d_rdata      <= '0;
            d_ack        <= 1'b0;
            d_error      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_b_en     <= '0;
            mem_w_en     <= 1'b0;
        end else begin
            // Acks and errors are single-cycle pulses raised only on entry to RESP.
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_error <= 1'b0;
            d_error <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    err_q <= 1'b0;
                    if (i_req || d_req) begin
                        win_q        <= grant;
                        last_grant_q <= grant;
                        state_q      <= StIssue;
                        // The mem_* registers double as the request latch.
                        if (grant == PORT_I) begin
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            mem_b_en  <= FETCH_BEN;
                            mem_w_en  <= 1'b0;
                        end else begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_b_en  <= d_b_en;
                            mem_w_en  <= d_w_en;
                        end
                    end
                end

                StIssue: begin
                    if (mem_error) begin
                        err_q <= 1'b1;
                    end
                    if (!mem_stall) begin
                        // Drop the write strobe so the write lands exactly once.
                        mem_w_en <= 1'b0;
                        cnt_q    <= CNT_INIT;
                        state_q  <= StWait;
                    end
                end

                StWait: begin
                    if (mem_error) begin
                        err_q <= 1'b1;
                    end
                    if (cnt_q == 4'd0) begin
                        mem_b_en <= '0;
                        state_q  <= StResp;
                        // Fold in this cycle's mem_error so a late error is not missed.
                        if (win_q == PORT_I) begin
                            i_rdata <= mem_rdata;
                            i_ack   <= 1'b1;
                            i_error <= err_q | mem_error;
                        end else begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                            d_error <= err_q | mem_error;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                StResp: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Shares the single-ported sram between the core's instruction-fetch port (read-only) and data port (read/write, byte-enabled).
- Accepts one request at a time through a req/ack handshake.
- Arbitrates round-robin when both ports request together.
- Sequences the sram over a fixed access window and returns read data and error status to the winning port.
- Sits between the multi-cycle core's fetch/load-store logic and the sram instance.

Parameters:
ADDR_W, 32, address width of all ports.
DATA_W, 32, data width of all ports. Only 32 is supported, because byte enables are 4 bits.
MEM_LAT, 2, cycles from the end of the issue cycle to valid mem_rdata. Legal range is 1..15.

Ports:
gclk  in  1  global clock
reset  in  1  synchronous, active-high reset
i_req  in  1  fetch request; held with i_addr stable until i_ack
i_addr  in  ADDR_W  fetch byte address
i_rdata  out  DATA_W  fetch read data; valid when i_ack=1
i_ack  out  1  one-cycle completion pulse for fetch
i_error  out  1  fetch error; valid when i_ack=1
d_req  in  1  data request; held with d_* stable until d_ack
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  write data
d_b_en  in  4  byte enables; must be nonzero when d_req=1
d_w_en  in  1  1=write, 0=read
d_rdata  out  DATA_W  data read data; valid when d_ack=1
d_ack  out  1  one-cycle completion pulse for data
d_error  out  1  data error; valid when d_ack=1
mem_addr  out  ADDR_W  sram address
mem_wdata  out  DATA_W  sram write data
mem_b_en  out  4  sram byte enables
mem_w_en  out  1  sram write enable
mem_rdata  in  DATA_W  sram read data
mem_stall  in  1  sram stall
mem_error  in  1  sram error
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, reset=1 at a gclk edge):
  - state=IDLE, last_grant=DATA (so fetch wins the first tie).
  - All outputs 0: acks, errors, rdata, mem_b_en, mem_w_en, mem_addr, mem_wdata, busy.
  - Error latch cleared.
- Reset mid-transaction aborts it; no ack is ever issued for the aborted request.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, select a winner and go to ISSUE. Latch winner id, addr, wdata, b_en and w_en into internal registers.
  - For a fetch winner, b_en is forced to 4'hF and w_en to 0.
  - Error latch is cleared.
- Arbitration:
  - Only one request pending: it wins.
  - Both pending: the port not equal to last_grant wins.
  - last_grant is updated on entry to ISSUE.
- ISSUE:
  - mem_addr, mem_wdata, mem_b_en and mem_w_en are driven from the latched request.
  - If mem_stall=1, stay in ISSUE and keep driving.
  - Otherwise go to WAIT with cnt=MEM_LAT-1.
- WAIT:
  - mem_addr and mem_b_en stay driven so the sram keeps presenting read data. mem_w_en=0, so a write happens exactly once.
  - cnt decrements each cycle.
  - At cnt=0, capture mem_rdata into the winner's rdata register and go to RESP.
- Errors: mem_error sampled high in any ISSUE or WAIT cycle sets the error latch.
- RESP:
  - Winner's ack=1 for exactly one cycle; its error output equals the latch.
  - mem_b_en=0. Next state is IDLE.
- Timing, with req sampled at edge T and no stall:
  - ISSUE at T+1, WAIT spans MEM_LAT cycles, ack at T+2+MEM_LAT.
  - Default MEM_LAT=2: ack at T+4.
  - Each mem_stall cycle adds one cycle.
- Write data: rdata on a write returns the captured mem_rdata; it is don't-care to the requester.
- Rdata hold: an ack'd port's rdata register holds its value until that port's next ack. The loser's outputs are unchanged.
- Requests seen only in IDLE: a req still high in the cycle after ack is treated as a new request, so requesters must drop req on ack. A req raised while busy waits, and no request is lost.
- Back-to-back: with both ports requesting continuously, grants alternate I,D,I,D with no idle gap other than the IDLE sampling cycle.
- Invariant: i_ack and d_ack are never high together.

Decomposition:
- Shared package sram_arb_pkg holds:
  - FSM state encodings (2-bit).
  - Port-id constants PORT_I=0 and PORT_D=1.
  - Constant FETCH_BEN=4'hF.
- One sub-module, rr_arb2: a 2-request round-robin picker. Inputs: req[1:0] and last_grant. Output: grant id. Purely combinational.
- FSM, counter and latches live in the top module.

Test Plan:
- Reset held 3 cycles with i_req=1 -> all outputs 0, no ack. After release, i_ack fires at the 4th edge after req is first sampled.
- Data write d_addr=0x10, d_wdata=0xDEADBEEF, d_b_en=4'hF; then fetch i_addr=0x10 -> i_rdata=0xDEADBEEF, i_error=0.
- Byte write d_b_en=4'b0010, d_wdata=0x0000AB00 onto 0x11223344 at 0x20; then data read -> d_rdata=0x1122AB44.
- i_req and d_req both held continuously for 4 transactions -> ack order I,D,I,D; acks never coincide; last_grant alternates.
- mem_stall high for 3 cycles in ISSUE -> mem signals stable throughout, ack delayed to T+7. mem_error pulsed during WAIT -> d_error=1 with d_ack.
- reset asserted during WAIT -> no ack; next request completes normally with correct data.
